dst_arb: RTL and testbench
==========================

# dst_arb

Destination-port arbiter between two 64-bit packed-output producers (codec packer and copy/xor engine) and the single DMA destination write port. It replaces the shared tri-state `m_dst` bus with a registered, round-robin, job-granular mux. A grant is held for a whole job, from grant until the owner's end strobe. The block sits between the producer engines and the destination write FIFO, in the `wb_clk_i` domain.

## Interface
No parameters.
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `req0_i`, `req1_i`  in  1  job request, level; held until the job's `endn` is sampled low
- `gnt0_o`, `gnt1_o`  out  1  registered grant, one-hot or zero
- `s0_dst`, `s1_dst`  in  64  producer data
- `s0_dst_putn`, `s1_dst_putn`  in  1  active-low word strobe
- `s0_dst_last`, `s1_dst_last`  in  1  last-word flag
- `s0_endn`, `s1_endn`  in  1  active-low job-end strobe
- `m_dst`  out  64  registered data to destination port
- `m_dst_putn`  out  1  active-low word strobe
- `m_dst_last`  out  1  last flag
- `m_endn`  out  1  active-low job end
- `busy_o`  out  1  high in OWN0/OWN1/GAP
- `err_o`  out  1  one-cycle protocol-violation pulse
- `wcnt0_o`, `wcnt1_o`  out  16  per-job forwarded word count; present only with `DST_ARB_CNT_EN`

## Operation
- States: IDLE, OWN0, OWN1, GAP. Round-robin pointer `ptr` (0 = requester 0 preferred).
- IDLE: if exactly one request is high, that requester is granted. If both are high, requester `ptr` is granted. Entering OWNn raises `gntn_o`.
- OWNn: source n is forwarded through one register stage.
  - `m_dst` loads `sn_dst` only when `sn_dst_putn`==0; otherwise it holds.
  - `m_dst_putn`, `m_dst_last`, `m_endn` are registered copies of source n's signals.
- OWNn, `sn_endn`==0 sampled: go to GAP and set `ptr` to the other requester. `m_endn` goes low for that one cycle, in the GAP cycle.
- OWNn, `reqn_i` drops with `sn_endn`==1 (abort): go to GAP, `err_o` pulses, `m_endn` stays 1, `ptr` goes to the other requester.
- GAP: grants low; `m_dst_putn`=1, `m_dst_last`=0. Always returns to IDLE next cycle.
- IDLE/GAP outputs: `m_dst_putn`=1, `m_dst_last`=0, `m_endn`=1 (except the GAP end cycle above); `m_dst` holds.
- `err_o` also pulses when the non-granted source drives `putn`=0 or `endn`=0. That source's data is discarded.
- `putn` and `endn` low in the same cycle: the word is forwarded, and `m_dst_putn`=0 and `m_endn`=0 appear in the same output cycle.
- Reset (any cycle, including mid-job): state IDLE, `ptr`=0, grants 0, `m_dst`=0, `m_dst_putn`=1, `m_dst_last`=0, `m_endn`=1, `busy_o`=0, `err_o`=0, counters 0. An in-flight job is dropped with no `m_endn`.

## Timing
- Request sampled at cycle t in IDLE -> `gntn_o`=1 at t+1.
- Source signals at cycle t while granted -> `m_*` at t+1; fixed one-cycle latency, no backpressure.
- `sn_endn` low at t -> grant low and `m_endn` low at t+1 (GAP), IDLE at t+2. Earliest next grant is at t+3.
- Minimum gap between jobs: 2 cycles with `gnt*`=0.
- A source asserting `putn` in the same cycle it is first granted is legal. Words presented before the grant are not forwarded and are flagged by `err_o`.

## Configuration
- `DST_ARB_CNT_EN` defined:
  - `wcnt0_o`/`wcnt1_o` exist.
  - `wcntn` clears to 0 on the cycle OWNn is entered.
  - Increments by 1 per forwarded word (`sn_dst_putn`==0 in OWNn), saturating at 16'hFFFF.
  - Holds after the job ends until the next grant to the same requester.
- Not defined: ports and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, `req0_i`=1, source 0 sends 4 words 0x1..0x4 then `endn`: `gnt0_o` at t+1, `m_dst` 0x1..0x4 each one cycle late, `m_endn` low 1 cycle, GAP, `busy_o` drops at end; `wcnt0_o`=4.
- Both requests high in IDLE after reset: requester 0 is granted first. After its `endn`, requester 1 is granted at endn+3 with no overlap of `gnt0_o`/`gnt1_o`.
- Requester 1 drives `putn`=0 with data 0xDEAD while 0 owns: `err_o` pulses one cycle; 0xDEAD never appears on `m_dst`.
- Requester 0 drops `req0_i` mid-job after 2 words: `err_o` pulse, GAP with `m_endn`=1, IDLE, `ptr`=1.
- `wb_rst_i` asserted for 1 cycle mid-job: next cycle all outputs are at their reset values and state is IDLE. A re-raised request is granted one cycle after reset deasserts.
- `DST_ARB_CNT_EN`: 65540 words in one job -> `wcnt0_o`=16'hFFFF (saturated).

Source files
------------

// File: rtl/dst_arb.sv
// Round-robin, job-granular arbiter muxing two packed-output producers onto the
// destination write port. Optional per-job word counters behind DST_ARB_CNT_EN.
module dst_arb (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  input  logic [63:0] s0_dst,
  input  logic        s0_dst_putn,
  input  logic        s0_dst_last,
  input  logic        s0_endn,
  input  logic [63:0] s1_dst,
  input  logic        s1_dst_putn,
  input  logic        s1_dst_last,
  input  logic        s1_endn,
  output logic [63:0] m_dst,
  output logic        m_dst_putn,
  output logic        m_dst_last,
  output logic        m_endn,
  output logic        busy_o,
  output logic        err_o
`ifdef DST_ARB_CNT_EN
  ,
  output logic [15:0] wcnt0_o,
  output logic [15:0] wcnt1_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [63:0] m_dst_q, m_dst_d;
  logic        m_putn_q, m_putn_d;
  logic        m_last_q, m_last_d;
  logic        m_endn_q, m_endn_d;
  logic        err_q, err_d;

  logic        own, own1;
  logic [63:0] cur_dst;
  logic        cur_putn, cur_last, cur_endn, cur_req;
  logic        viol0, viol1;

  always_comb begin
    own      = (state_q == OWN0) || (state_q == OWN1);
    own1     = (state_q == OWN1);
    cur_dst  = own1 ? s1_dst      : s0_dst;
    cur_putn = own1 ? s1_dst_putn : s0_dst_putn;
    cur_last = own1 ? s1_dst_last : s0_dst_last;
    cur_endn = own1 ? s1_endn     : s0_endn;
    cur_req  = own1 ? req1_i      : req0_i;
    viol0    = !s0_dst_putn || !s0_endn;
    viol1    = !s1_dst_putn || !s1_endn;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    m_dst_d  = m_dst_q;
    m_putn_d = 1'b1;
    m_last_d = 1'b0;
    m_endn_d = 1'b1;
    // any strobe from a source that does not own the port is a violation
    err_d    = (viol0 && (state_q != OWN0)) || (viol1 && (state_q != OWN1));
    case (state_q)
      IDLE: begin
        if (req0_i && (!req1_i || !ptr_q)) state_d = OWN0;
        else if (req1_i)                   state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!cur_putn) m_dst_d = cur_dst;
        m_putn_d = cur_putn;
        m_last_d = cur_last;
        m_endn_d = cur_endn;
        if (!cur_endn || !cur_req) begin
          state_d = GAP;
          ptr_d   = !own1;
          if (cur_endn) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      m_dst_q  <= '0;
      m_putn_q <= 1'b1;
      m_last_q <= 1'b0;
      m_endn_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      m_dst_q  <= m_dst_d;
      m_putn_q <= m_putn_d;
      m_last_q <= m_last_d;
      m_endn_q <= m_endn_d;
      err_q    <= err_d;
    end
  end

  assign gnt0_o     = (state_q == OWN0);
  assign gnt1_o     = (state_q == OWN1);
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign m_dst      = m_dst_q;
  assign m_dst_putn = m_putn_q;
  assign m_dst_last = m_last_q;
  assign m_endn     = m_endn_q;

`ifdef DST_ARB_CNT_EN
  logic [1:0][15:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == IDLE && state_d == OWN0) wcnt_d[0] = '0;
    if (state_q == IDLE && state_d == OWN1) wcnt_d[1] = '0;
    if (own && !cur_putn && wcnt_d[own1] != 16'hFFFF)
      wcnt_d[own1] = wcnt_d[own1] + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end

  assign wcnt0_o = wcnt_q[0];
  assign wcnt1_o = wcnt_q[1];
`endif

endmodule

// File: tb/tb_dst_arb.sv
// Directed bench for dst_arb: ownership-level reference model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_dst_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, putn, last, endn;
  logic [63:0] dst [2];
  logic        gnt0, gnt1, m_putn, m_last, m_endn, busy, err;
  logic [63:0] m_dst;
`ifdef DST_ARB_CNT_EN
  logic [15:0] wcnt0, wcnt1;
`endif

  int checks = 0;
  int failures = 0;
  bit run_cmp = 0;
  bit seen_dead = 0;

  always #5 clk = ~clk;

  dst_arb dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req0_i(req[0]), .req1_i(req[1]),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .s0_dst(dst[0]), .s0_dst_putn(putn[0]), .s0_dst_last(last[0]), .s0_endn(endn[0]),
    .s1_dst(dst[1]), .s1_dst_putn(putn[1]), .s1_dst_last(last[1]), .s1_endn(endn[1]),
    .m_dst(m_dst), .m_dst_putn(m_putn), .m_dst_last(m_last), .m_endn(m_endn),
    .busy_o(busy), .err_o(err)
`ifdef DST_ARB_CNT_EN
    , .wcnt0_o(wcnt0), .wcnt1_o(wcnt1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the port, whether we are in the gap, who is next.
  int          owner;
  bit          gap;
  int          rr;
  logic [63:0] e_mdst;
  logic        e_putn, e_last, e_endn, e_err;
  logic [15:0] ecnt [2];

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; gap = 0; rr = 0;
      e_mdst = '0; e_putn = 1; e_last = 0; e_endn = 1; e_err = 0;
      ecnt[0] = '0; ecnt[1] = '0;
    end else begin
      e_err = 0;
      for (int s = 0; s < 2; s++)
        if (s != owner && (!putn[s] || !endn[s])) e_err = 1;
      e_putn = 1; e_last = 0; e_endn = 1;
      if (owner >= 0) begin
        int o;
        o = owner;
        if (!putn[o]) begin
          e_mdst = dst[o];
          if (ecnt[o] != 16'hFFFF) ecnt[o] = ecnt[o] + 16'd1;
        end
        e_putn = putn[o]; e_last = last[o]; e_endn = endn[o];
        if (!endn[o] || !req[o]) begin
          if (endn[o]) e_err = 1;
          owner = -1; gap = 1; rr = 1 - o;
        end
      end else if (gap) begin
        gap = 0;
      end else begin
        if (req[0] && req[1]) owner = rr;
        else if (req[0])      owner = 0;
        else if (req[1])      owner = 1;
        if (owner >= 0) ecnt[owner] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_dst === 64'hDEAD) seen_dead = 1;
    if (run_cmp) begin
      chk("gnt0", gnt0, owner == 0);
      chk("gnt1", gnt1, owner == 1);
      chk("busy", busy, (owner >= 0) || gap);
      chk("err", err, e_err);
      chk("m_dst", m_dst, e_mdst);
      chk("m_putn", m_putn, e_putn);
      chk("m_last", m_last, e_last);
      chk("m_endn", m_endn, e_endn);
      if (gnt0 && gnt1) chk("gnt_overlap", 1, 0);
`ifdef DST_ARB_CNT_EN
      chk("wcnt0", wcnt0, ecnt[0]);
      chk("wcnt1", wcnt1, ecnt[1]);
`endif
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_src(input int s);
    putn[s] = 1; last[s] = 0; endn[s] = 1;
  endtask

  task automatic word(input int s, input logic [63:0] d, input logic l);
    dst[s] = d; putn[s] = 0; last[s] = l;
    tick();
    putn[s] = 1; last[s] = 0;
  endtask

  // endn cycle, then GAP cycle (request released), then IDLE cycle
  task automatic finish_job(input int s);
    endn[s] = 0;
    tick();
    endn[s] = 1; req[s] = 0;
  endtask

  initial begin
    rst = 1; req = 0; putn = 2'b11; last = 0; endn = 2'b11;
    dst[0] = '0; dst[1] = '0;
    tick(); tick();
    run_cmp = 1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_putn", m_putn, 1);
    rst = 0;

    // single job from requester 0, 4 words
    req[0] = 1;
    tick();
    chk("t1_gnt0_at_t1", gnt0, 1);
    for (int i = 0; i < 4; i++) begin
      word(0, 64'(i + 1), i == 3);
      chk("t1_word", m_dst, 64'(i + 1));
    end
    finish_job(0);
    chk("t1_gap_endn", m_endn, 0);
    chk("t1_gap_gnt0", gnt0, 0);
    chk("t1_gap_mdst", m_dst, 64'h4);
`ifdef DST_ARB_CNT_EN
    chk("t1_wcnt0", wcnt0, 16'd4);
`endif
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_endn", m_endn, 1);

    // both request after reset: 0 first, then 1 at endn+3
    rst = 1; tick(); rst = 0;
    req = 2'b11;
    tick();
    chk("t2_gnt0_first", gnt0, 1);
    word(0, 64'h11, 0);
    dst[0] = 64'h55; putn[0] = 0; last[0] = 1;
    finish_job(0);
    idle_src(0);
    chk("t2_same_cycle_putn", m_putn, 0);
    chk("t2_same_cycle_endn", m_endn, 0);
    chk("t2_same_cycle_dst", m_dst, 64'h55);
    tick();
    chk("t2_idle_gnt1", gnt1, 0);
    tick();
    chk("t2_gnt1_at_t3", gnt1, 1);
    word(1, 64'hA1, 0);
    word(1, 64'hA2, 1);
    finish_job(1);
    tick(); tick();

    // non-granted source strobes 0xDEAD during owner 0's job
    req[0] = 1;
    tick();
    chk("t3_gnt0", gnt0, 1);
    dst[1] = 64'hDEAD; putn[1] = 0;
    word(0, 64'h77, 0);
    putn[1] = 1;
    chk("t3_err", err, 1);
    chk("t3_dst", m_dst, 64'h77);
    tick();
    chk("t3_err_one_cycle", err, 0);
    finish_job(0);
    tick(); tick();

    // abort: requester 0 drops mid-job after 2 words
    req[0] = 1;
    tick();
    word(0, 64'h201, 0);
    word(0, 64'h202, 0);
    req[0] = 0;
    tick();
    chk("t4_abort_err", err, 1);
    chk("t4_abort_endn", m_endn, 1);
    chk("t4_abort_busy", busy, 1);
    chk("t4_abort_gnt0", gnt0, 0);
    tick();
    chk("t4_idle_busy", busy, 0);
    req = 2'b11;
    tick();
    chk("t4_ptr1_gnt1", gnt1, 1);
    req[0] = 0;
    finish_job(1);
    tick(); tick();

    // reset for one cycle mid-job
    req[0] = 1;
    tick();
    word(0, 64'h301, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_gnt0", gnt0, 0);
    chk("t5_rst_mdst", m_dst, 64'h0);
    chk("t5_rst_endn", m_endn, 1);
    chk("t5_rst_busy", busy, 0);
    tick();
    chk("t5_regrant", gnt0, 1);
    finish_job(0);
    tick(); tick();

    // strobe before grant is flagged, never forwarded
    dst[1] = 64'hBEEF; putn[1] = 0;
    tick();
    putn[1] = 1;
    chk("t6_early_err", err, 1);
    chk("t6_early_gnt", gnt1, 0);
    tick();

`ifdef DST_ARB_CNT_EN
    req[0] = 1;
    tick();
    putn[0] = 0;
    for (int i = 0; i < 65540; i++) begin
      dst[0] = 64'(i);
      tick();
    end
    putn[0] = 1;
    chk("t7_wcnt_sat", wcnt0, 16'hFFFF);
    finish_job(0);
    tick(); tick();
    chk("t7_wcnt_hold", wcnt0, 16'hFFFF);
`endif

    chk("never_dead", seen_dead, 0);
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
